// File: rtl/mdu_iterative_if.sv
// mdu_iterative_if: EX-stage request/response bundle between the pipeline and the multiply/divide unit
interface mdu_iterative_if;
   logic        startE;
   logic [1:0]  opE;
   logic [31:0] srcAE;
   logic [31:0] srcBE;
   logic        StallE;
   logic        Exception_clean;
   logic        ALU_stall;
   logic        ALU_done;
   logic [31:0] resHi;
   logic [31:0] resLo;
   modport master (output startE, opE, srcAE, srcBE, StallE, Exception_clean,
                   input ALU_stall, ALU_done, resHi, resLo);
   modport slave (input startE, opE, srcAE, srcBE, StallE, Exception_clean,
                  output ALU_stall, ALU_done, resHi, resLo);
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative MULT/MULTU/DIV/DIVU with stall handshake; MDU_FAST_MUL_EN selects a registered multiplier for MULT/MULTU
module mdu_iterative #(
   parameter int ITER = 32
) (
   input logic clk,
   input logic rst,
   mdu_iterative_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int CW = $clog2(ITER);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic consumed_q, consumed_d, rsign_q, rsign_d, remsign_q, remsign_d;
   logic [1:0] op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b, res_hi, res_lo;
   logic [63:0] acc_q, acc_d, acc_n, prod, fast_p;
   logic [32:0] msum, dshift, ddiff;
   logic accept, sgn, is_div, bzero, keep_a, keep_b, last, fast_mul;
`ifdef MDU_FAST_MUL_EN
   localparam logic FAST_MUL = 1'b1;
   assign fast_p = $signed({{32{!op_q[0] & a_q[31]}}, a_q}) * $signed({{32{!op_q[0] & b_q[31]}}, b_q});
`else
   localparam logic FAST_MUL = 1'b0;
   assign fast_p = '0;
`endif
   assign fast_mul = FAST_MUL && !op_q[1];
   assign accept = state_q == IDLE && bus.startE && !consumed_q && !bus.Exception_clean;
   assign bus.ALU_stall = accept || state_q != IDLE;
   assign bus.ALU_done = state_q == DONE;
   assign bus.resHi = hi_q;
   assign bus.resLo = lo_q;
   assign sgn = !bus.opE[0];
   assign is_div = bus.opE[1];
   assign bzero = is_div && bus.srcBE == '0;
   // divide-by-zero keeps the raw dividend so it falls out as the remainder unchanged
   assign keep_b = !sgn || (FAST_MUL && !is_div);
   assign keep_a = keep_b || bzero;
   assign abs_a = !keep_a && bus.srcAE[31] ? -bus.srcAE : bus.srcAE;
   assign abs_b = !keep_b && bus.srcBE[31] ? -bus.srcBE : bus.srcBE;
   assign last = cnt_q == CW'(ITER - 1);
   assign msum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
   assign dshift = acc_q[63:31];
   assign ddiff = dshift - {1'b0, b_q};
   assign acc_n = op_q[1] ? {ddiff[32] ? dshift[31:0] : ddiff[31:0], acc_q[30:0], !ddiff[32]}
                          : {msum, acc_q[31:1]};
   assign prod = rsign_q ? -acc_n : acc_n;
   assign res_hi = op_q[1] ? (remsign_q ? -acc_n[63:32] : acc_n[63:32]) : prod[63:32];
   assign res_lo = op_q[1] ? (rsign_q ? -acc_n[31:0] : acc_n[31:0]) : prod[31:0];
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      a_d = a_q;
      b_d = b_q;
      op_d = op_q;
      rsign_d = rsign_q;
      remsign_d = remsign_q;
      acc_d = acc_q;
      hi_d = hi_q;
      lo_d = lo_q;
      consumed_d = (consumed_q || state_q == DONE) && bus.StallE && !bus.Exception_clean;
      if (accept) begin
         state_d = BUSY;
         cnt_d = '0;
         a_d = abs_a;
         b_d = abs_b;
         op_d = bus.opE;
         rsign_d = sgn && !bzero && (bus.srcAE[31] ^ bus.srcBE[31]);
         remsign_d = sgn && !bzero && bus.srcAE[31];
         acc_d = {32'd0, is_div ? abs_a : abs_b};
      end else if (bus.Exception_clean) begin
         state_d = IDLE;
      end else if (state_q == BUSY) begin
         acc_d = acc_n;
         cnt_d = cnt_q + CW'(1);
         state_d = fast_mul || last ? DONE : BUSY;
         hi_d = fast_mul ? fast_p[63:32] : last ? res_hi : hi_q;
         lo_d = fast_mul ? fast_p[31:0] : last ? res_lo : lo_q;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         consumed_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         rsign_q <= 1'b0;
         remsign_q <= 1'b0;
         acc_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         consumed_q <= consumed_d;
         a_q <= a_d;
         b_q <= b_d;
         op_q <= op_d;
         rsign_q <= rsign_d;
         remsign_q <= remsign_d;
         acc_q <= acc_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
endmodule
